// File: rtl/output_argmax.sv
// Purpose : argmax over one frame of signed output-layer neuron activations;
//           reports the winning class index, its score and a frame-length error flag.
// Latency : result_valid rises the cycle after the frame-end transfer.
// Backpressure: the result is held while result_ready = 0; in_ready stays 0 meanwhile.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   in_valid/ready    input handshake; in_data is a signed activation, in_last ends a frame
//   result_valid/ready result handshake; result_class/result_score/frame_error
//                     stay stable while result_valid is high
module output_argmax #(
  parameter int num_classes = 10,
  parameter int resolution  = 8,
  parameter int index_width = $clog2(num_classes)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [resolution-1:0] in_data,
  input  logic                         in_last,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [index_width-1:0]       result_class,
  output logic signed [resolution-1:0] result_score,
  output logic                         frame_error
);

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  localparam logic [index_width-1:0] last_idx = index_width'(num_classes - 1);

  state_t                         state;
  logic [index_width-1:0]         cnt;
  logic [index_width-1:0]         idx_reg;
  logic signed [resolution-1:0]   max_reg;
  logic                           err_reg;

  logic xfer;
  logic last_slot;
  logic frame_end;
  logic take;

  // Handshake outputs depend on the registered state only.
  assign in_ready     = (state == COLLECT);
  assign result_valid = (state == RESULT);
  assign result_class = idx_reg;
  assign result_score = max_reg;
  assign frame_error  = err_reg;

  assign xfer      = in_valid && in_ready;
  assign last_slot = (cnt == last_idx);
  // A frame ends on in_last or on the num_classes-th sample, whichever comes first,
  // so cnt never needs to go past last_idx.
  assign frame_end = xfer && (in_last || last_slot);
  // First sample of a frame always loads, so stale max_reg never needs clearing.
  // Strict compare keeps the lowest index on ties.
  assign take      = (cnt == '0) || (in_data > max_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= COLLECT;
      cnt     <= '0;
      idx_reg <= '0;
      max_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            if (take) begin
              max_reg <= in_data;
              idx_reg <= cnt;
            end
            if (frame_end) begin
              state   <= RESULT;
              cnt     <= '0;
              // Error when in_last and the expected final slot disagree.
              err_reg <= (in_last != last_slot);
            end else begin
              cnt <= cnt + index_width'(1);
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            state <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
module tb_output_argmax;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              in_last;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_class;
  logic signed [7:0] result_score;
  logic              frame_error;

  int errors;
  int checks;
  int fv[10];

  typedef struct {
    string name;
    int    n;
    int    last_pos;
    int    vals[10];
    int    exp_class;
    int    exp_score;
    int    exp_err;
  } vec_t;

  vec_t tbl[7];

  output_argmax #(.num_classes(10), .resolution(8), .index_width(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},     int'(in_ready), 1);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_class"},        int'(result_class), 0);
    check({tag, "_score"},        int'(result_score), 0);
    check({tag, "_frame_error"},  int'(frame_error), 0);
  endtask

  // Drives fv[0..n-1] starting at a negedge; returns at the negedge after the last transfer.
  task automatic feed(input string tag, input int n, input int last_pos, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = 8'(fv[i]);
      in_last  = (i == last_pos);
      if (i == 0)     check({tag, "_in_ready_start"}, int'(in_ready), 1);
      if (i == n - 1) check({tag, "_rv_before_end"}, int'(result_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int c, input int s, input int e);
    check({tag, "_result_valid"}, int'(result_valid), 1);
    check({tag, "_in_ready_low"}, int'(in_ready), 0);
    check({tag, "_class"},        int'(result_class), c);
    check({tag, "_score"},        int'(result_score), s);
    check({tag, "_frame_error"},  int'(frame_error), e);
  endtask

  // Handshake with result_ready already 1: in_ready must be back the next cycle.
  task automatic finish_result(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_after"}, int'(in_ready), 1);
    check({tag, "_rv_after"},       int'(result_valid), 0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    result_ready = 1'b1;

    tbl[0] = '{"basic",     10, 9,  '{3, -5, 7, 2, 7, 0, -1, 4, 6, 1}, 2, 7, 0};
    tbl[1] = '{"all_min",   10, 9,  '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}, 0, -128, 0};
    tbl[2] = '{"max_last",  10, 9,  '{5, -3, 0, 100, -100, 126, 1, 2, 3, 127}, 9, 127, 0};
    tbl[3] = '{"short4",    4,  3,  '{1, 9, -2, 3, 0, 0, 0, 0, 0, 0}, 1, 9, 1};
    tbl[4] = '{"tie_first", 10, 9,  '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -1}, 0, -1, 0};
    tbl[5] = '{"no_last",   10, -1, '{10, 20, 30, 40, 50, 60, 70, 80, 90, -128}, 8, 90, 1};
    tbl[6] = '{"single",    1,  0,  '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 42, 1};

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven frames, back-to-back, result accepted in its first cycle.
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 10; k++) fv[k] = tbl[t].vals[k];
      feed(tbl[t].name, tbl[t].n, tbl[t].last_pos, 1'b0);
      expect_result(tbl[t].name, tbl[t].exp_class, tbl[t].exp_score, tbl[t].exp_err);
      finish_result(tbl[t].name);
    end

    // Backpressure: result held 5 cycles, input offered meanwhile must not be taken.
    result_ready = 1'b0;
    fv = '{-7, 12, 3, 12, -50, 0, 11, 1, 2, -3};
    feed("bp", 10, -1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'sd127;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_result($sformatf("bp_hold%0d", k), 1, 12, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    finish_result("bp");
    fv = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 3};
    feed("after_bp", 10, 9, 1'b0);
    expect_result("after_bp", 8, 12, 0);
    finish_result("after_bp");

    // Random frames with input gaps against a scanning reference.
    for (int f = 0; f < 6; f++) begin
      int bi;
      for (int k = 0; k < 10; k++) fv[k] = int'($urandom_range(0, 255)) - 128;
      bi = 0;
      for (int k = 1; k < 10; k++) if (fv[k] > fv[bi]) bi = k;
      feed($sformatf("rand%0d", f), 10, 9, 1'b1);
      expect_result($sformatf("rand%0d", f), bi, fv[bi], 0);
      finish_result($sformatf("rand%0d", f));
    end

    // Reset mid-frame: outputs return to reset values without a clock edge.
    fv = '{100, 1, 2, 3, 4, 0, 0, 0, 0, 0};
    feed("mid", 5, -1, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fv = '{-20, -10, 5, 6, -1, 6, 0, 0, 1, 2};
    feed("post_mid", 10, 9, 1'b0);
    expect_result("post_mid", 3, 6, 0);
    finish_result("post_mid");

    // Reset while a result is pending.
    result_ready = 1'b0;
    fv = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
    feed("pend", 10, 9, 1'b0);
    expect_result("pend", 4, 50, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("pend_reset");
    @(negedge clk);
    reset        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    fv = '{0, -1, 0, 33, 2, 33, -128, 127, 126, 1};
    feed("post_pend", 10, 9, 1'b0);
    expect_result("post_pend", 7, 127, 0);
    finish_result("post_pend");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
# output_argmax

Final-layer classification stage for the handwritten digit recognition datapath. Consumes the signed output-layer neuron activations one per handshake, in class order 0..num_classes-1, tracks the running maximum, and presents the winning digit index and its score through a valid/ready result port. It sits directly downstream of the output-layer neuron wrappers and is the last stage before the result is displayed or reported.

## Interface
- num_classes, 10, number of output neurons per frame; must be ≥2
- resolution, 8, bit width of each signed neuron output
- index_width, $clog2(num_classes), width of the class index
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserted when 0
- in_valid  input  1  in_data/in_last are valid this cycle
- in_ready  output  1  stage accepts a neuron output this cycle
- in_data  input  resolution  signed two's-complement neuron output
- in_last  input  1  marks the final neuron output of a frame
- result_valid  output  1  result_class/result_score/frame_error valid
- result_ready  input  1  downstream accepts the result
- result_class  output  index_width  index of the maximum neuron output
- result_score  output  resolution  signed maximum value
- frame_error  output  1  frame length disagreed with num_classes

## Operation
- Two states: COLLECT, RESULT. Transfer = in_valid && in_ready; result handshake = result_valid && result_ready.
- COLLECT: in_ready = 1, result_valid = 0. Counter cnt (index_width bits) gives the class index of the current input.
- On each transfer: if cnt == 0 or in_data > max_reg (signed, strict), max_reg <= in_data and idx_reg <= cnt; cnt <= cnt + 1.
- Ties keep the lowest index (strict compare); first sample always loads, so an all -2^(resolution-1) frame yields class 0.
- Frame end = transfer with in_last = 1 or with cnt == num_classes-1, whichever first. On frame end: state <= RESULT, cnt <= 0; update of max/idx from that final sample applies.
- frame_error <= 1 if at frame end (in_last == 1) != (cnt == num_classes-1), i.e. in_last early, or missing on the num_classes-th sample; else 0.
- RESULT: in_ready = 0, result_valid = 1; result_class = idx_reg, result_score = max_reg, frame_error stable until handshake. in_valid ignored.
- On result handshake: state <= COLLECT; max_reg/idx_reg need not clear (cnt == 0 forces reload).
- No arithmetic beyond compare and counter; cnt never exceeds num_classes-1, no wrap.

## Timing
- Reset (reset = 0, asynchronous): state COLLECT, cnt 0, max_reg 0, idx_reg 0, frame_error 0; outputs: in_ready 1, result_valid 0, result_class 0, result_score 0, frame_error 0.
- Reset mid-frame or while RESULT is pending discards the partial frame/result; first transfer after release is class 0.
- in_ready and result_valid are decoded from the registered state only (no combinational path from in_valid or result_ready).
- Latency: result_valid rises the cycle after the frame-end transfer.
- Result handshake in the first RESULT cycle: in_ready = 1 the next cycle. Minimum frame period num_classes + 1 cycles.
- Backpressure: result held indefinitely while result_ready = 0; no input accepted meanwhile.
- Gaps (in_valid = 0) in COLLECT leave all state unchanged.

## Test plan
- Reset then frame 3,-5,7,2,7,0,-1,4,6,1 (in_last on 10th), result_ready = 1 -> result_class 2, result_score 7, frame_error 0, result_valid one cycle after last transfer.
- Frame all -128 -> result_class 0, result_score -128; frame with max 127 at index 9 -> class 9, score 127.
- in_last on 4th sample (values 1,9,-2,3) -> class 1, score 9, frame_error 1; next full frame correct with frame_error 0.
- 10 samples with in_last = 0 -> result after 10th, frame_error 1; input with in_valid = 1 during RESULT not consumed (in_ready = 0).
- result_ready held 0 for 5 cycles -> outputs stable, result_valid stays 1; release -> in_ready = 1 next cycle, back-to-back frames at 11-cycle period with random in_valid gaps match reference model.
- reset pulled low after 5 samples and during a pending RESULT -> all outputs at reset values immediately; following frame classified correctly.
